// File: rtl/uart_pkg.sv
// Shared definitions for the UART command sequencer: FSM states, command word layout, defaults.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

    localparam int CMD_WIDTH_DEF   = 16;
    localparam int READ_WIDTH_DEF  = 8;
    localparam int TIMEOUT_CYC_DEF = 100000;

    // Command word: {rd, addr, data}; values below are for the default widths.
    localparam int CMD_RW_BIT = CMD_WIDTH_DEF - 1;
    localparam int ADDR_W     = CMD_WIDTH_DEF - READ_WIDTH_DEF - 1;
    localparam int ADDR_LSB   = READ_WIDTH_DEF;
    localparam int DATA_LSB   = 0;

    function automatic int addr_width(input int cmd_w, input int rd_w);
        return cmd_w - rd_w - 1;
    endfunction

endpackage

// File: rtl/uart_cmd_seq.sv
// Packs one register read/write into a UART command word and returns one response per request.
// Latency: write rsp one cycle after cmd accept; read rsp one cycle after read_rdy or on timeout.
// Backpressure: req_rdy only in IDLE; cmd_vld held with stable cmd_data until cmd_rdy.
module uart_cmd_seq
    import uart_pkg::*;
#(
    parameter int CMD_WIDTH   = CMD_WIDTH_DEF,
    parameter int READ_WIDTH  = READ_WIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_vld,
    output logic                              req_rdy,
    input  logic                              req_wr,
    input  logic [CMD_WIDTH-READ_WIDTH-2:0]   req_addr,
    input  logic [READ_WIDTH-1:0]             req_wdata,
    output logic [CMD_WIDTH-1:0]              cmd_data,
    output logic                              cmd_vld,
    input  logic                              cmd_rdy,
    input  logic                              read_rdy,
    input  logic [READ_WIDTH-1:0]             read_data,
    output logic                              rsp_vld,
    output logic [READ_WIDTH-1:0]             rsp_data,
    output logic                              rsp_err,
    output logic                              busy
);

    localparam int AW    = addr_width(CMD_WIDTH, READ_WIDTH);
    localparam int RW_B  = CMD_WIDTH - 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    seq_state_t              state, state_nxt;
    logic [CMD_WIDTH-1:0]    cmd_q;
    logic [CNT_W-1:0]        cnt;
    logic [READ_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_err_q;
    logic                    timed_out;

    assign timed_out = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_vld) state_nxt = SEND;
            SEND:     if (cmd_rdy) state_nxt = cmd_q[RW_B] ? WAIT_RSP : DONE;
            WAIT_RSP: if (read_rdy || timed_out) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_q      <= '0;
            cnt        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        cmd_q[RW_B]                  <= ~req_wr;
                        cmd_q[RW_B-1 -: AW]          <= req_addr;
                        cmd_q[READ_WIDTH-1:0]        <= req_wr ? req_wdata : '0;
                    end
                end
                SEND: begin
                    cnt <= '0;
                    // Writes respond with zero data and no error.
                    if (cmd_rdy && !cmd_q[RW_B]) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response arriving on the last timeout cycle still counts as good.
                    if (read_rdy) begin
                        rsp_data_q <= read_data;
                        rsp_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_rdy  = (state == IDLE);
    assign cmd_vld  = (state == SEND);
    assign rsp_vld  = (state == DONE);
    assign busy     = (state != IDLE);
    assign cmd_data = cmd_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq with a short timeout; inputs change and outputs are checked on negedge.
module tb_uart_cmd_seq;
    import uart_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_rdy, req_wr;
    logic [6:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [15:0] cmd_data;
    logic        cmd_vld, cmd_rdy;
    logic        read_rdy;
    logic [7:0]  read_data;
    logic        rsp_vld;
    logic [7:0]  rsp_data;
    logic        rsp_err, busy;

    int vectors = 0;
    int miscompares = 0;
    int n_cmd, n_rsp;

    uart_cmd_seq #(.CMD_WIDTH(16), .READ_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .cmd_data(cmd_data), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .read_rdy(read_rdy), .read_data(read_data),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".req_rdy"}, 32'(req_rdy), 32'd1);
        chk({tag, ".cmd_vld"}, 32'(cmd_vld), 32'd0);
        chk({tag, ".cmd_data"}, 32'(cmd_data), 32'd0);
        chk({tag, ".rsp_vld"}, 32'(rsp_vld), 32'd0);
        chk({tag, ".rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        cmd_rdy = 1'b0; read_rdy = 1'b0; read_data = '0;
        nxt(); nxt();
        chk_reset_vals("reset");

        // Write 0x12 <- 0xA5, cmd_rdy high
        rst_n = 1'b1; req_vld = 1'b1; req_wr = 1'b1; req_addr = 7'h12; req_wdata = 8'hA5; cmd_rdy = 1'b1;
        nxt();
        chk("wr.cmd_vld", 32'(cmd_vld), 32'd1);
        chk("wr.cmd_data", 32'(cmd_data), 32'h12A5);
        chk("wr.busy", 32'(busy), 32'd1);
        chk("wr.req_rdy", 32'(req_rdy), 32'd0);
        req_vld = 1'b0; req_wdata = 8'h00;
        nxt();
        chk("wr.cmd_vld_drop", 32'(cmd_vld), 32'd0);
        chk("wr.rsp_vld", 32'(rsp_vld), 32'd1);
        chk("wr.rsp_err", 32'(rsp_err), 32'd0);
        chk("wr.rsp_data", 32'(rsp_data), 32'd0);
        cmd_rdy = 1'b0;
        nxt();
        chk("wr.rsp_pulse", 32'(rsp_vld), 32'd0);
        chk("wr.req_rdy_back", 32'(req_rdy), 32'd1);

        // Read 0x05 with 7-cycle command stall; fields change during SEND
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'h05; req_wdata = 8'hFF;
        for (int i = 0; i < 7; i++) begin
            nxt();
            chk("rd.stall_vld", 32'(cmd_vld), 32'd1);
            chk("rd.stall_data", 32'(cmd_data), 32'h8500);
            req_vld = 1'b0; req_addr = 7'h7F; req_wr = 1'b1; req_wdata = 8'h11;
        end
        cmd_rdy = 1'b1;
        nxt();
        cmd_rdy = 1'b0;
        chk("rd.wait_cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rd.wait_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            nxt();
            chk("rd.wait_no_rsp", 32'(rsp_vld), 32'd0);
        end
        read_rdy = 1'b1; read_data = 8'h3C;
        nxt();
        read_rdy = 1'b0; read_data = 8'h00;
        chk("rd.rsp_vld", 32'(rsp_vld), 32'd1);
        chk("rd.rsp_data", 32'(rsp_data), 32'h3C);
        chk("rd.rsp_err", 32'(rsp_err), 32'd0);
        nxt();
        chk("rd.req_rdy_back", 32'(req_rdy), 32'd1);

        // Read timeout: no read_rdy
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'h33; cmd_rdy = 1'b1;
        nxt();
        chk("to.cmd_vld", 32'(cmd_vld), 32'd1);
        req_vld = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            nxt();
            cmd_rdy = 1'b0;
            chk("to.no_rsp_early", 32'(rsp_vld), 32'd0);
        end
        nxt();
        chk("to.rsp_vld", 32'(rsp_vld), 32'd1);
        chk("to.rsp_err", 32'(rsp_err), 32'd1);
        chk("to.rsp_data", 32'(rsp_data), 32'd0);
        nxt();
        chk("to.req_rdy_back", 32'(req_rdy), 32'd1);
        chk("to.rsp_pulse", 32'(rsp_vld), 32'd0);

        // read_rdy on the last timeout cycle wins
        req_vld = 1'b1; req_addr = 7'h34; cmd_rdy = 1'b1;
        nxt();
        req_vld = 1'b0;
        for (int j = 1; j <= TO; j++) begin
            nxt();
            cmd_rdy = 1'b0;
            chk("race.no_rsp_early", 32'(rsp_vld), 32'd0);
            if (j == TO) begin
                read_rdy = 1'b1; read_data = 8'h77;
            end
        end
        nxt();
        read_rdy = 1'b0; read_data = 8'h00;
        chk("race.rsp_vld", 32'(rsp_vld), 32'd1);
        chk("race.rsp_data", 32'(rsp_data), 32'h77);
        chk("race.rsp_err", 32'(rsp_err), 32'd0);

        // Stray read_rdy while idle
        nxt();
        read_rdy = 1'b1; read_data = 8'h99;
        for (int i = 0; i < 3; i++) begin
            nxt();
            if (i == 1) read_rdy = 1'b0;
            chk("stray.rsp_vld", 32'(rsp_vld), 32'd0);
            chk("stray.busy", 32'(busy), 32'd0);
        end

        // Reset while waiting for a read response
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 7'h44; cmd_rdy = 1'b1;
        nxt();
        req_vld = 1'b0;
        nxt();
        cmd_rdy = 1'b0;
        chk("rst.in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        nxt();
        chk_reset_vals("rst.mid");
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nxt();
            chk("rst.no_rsp", 32'(rsp_vld), 32'd0);
        end
        req_vld = 1'b1; req_addr = 7'h01; cmd_rdy = 1'b1;
        nxt();
        chk("rst.next_cmd", 32'(cmd_data), 32'h8100);
        req_vld = 1'b0;
        nxt();
        cmd_rdy = 1'b0; read_rdy = 1'b1; read_data = 8'h5A;
        nxt();
        read_rdy = 1'b0;
        chk("rst.next_rsp_vld", 32'(rsp_vld), 32'd1);
        chk("rst.next_rsp_data", 32'(rsp_data), 32'h5A);
        chk("rst.next_rsp_err", 32'(rsp_err), 32'd0);
        nxt();

        // Back-to-back writes with req_vld held high; fields change every cycle
        n_cmd = 0; n_rsp = 0;
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 7'd0; req_wdata = 8'h10; cmd_rdy = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            nxt();
            if (cmd_vld) n_cmd++;
            if (rsp_vld) n_rsp++;
            chk("b2b.cmd_vld", 32'(cmd_vld), 32'((c % 3) == 1));
            chk("b2b.rsp_vld", 32'(rsp_vld), 32'((c % 3) == 2));
            if ((c % 3) == 1)
                chk("b2b.cmd_data", 32'(cmd_data), {16'h0, 1'b0, 7'(c - 1), 8'(8'h10 + c - 1)});
            if (c == 9) begin
                req_vld = 1'b0;
            end else begin
                req_addr = 7'(c); req_wdata = 8'(8'h10 + c);
            end
        end
        chk("b2b.n_cmd", 32'(n_cmd), 32'd3);
        chk("b2b.n_rsp", 32'(n_rsp), 32'd3);
        cmd_rdy = 1'b0;
        nxt();
        chk("b2b.idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
